// File: rtl/run_control_seq.sv
`default_nettype none
//==============================================================================
// Module   : run_control_seq
// Purpose  : Run-control sequencer for the on-board MIPS demo. Walks the
//            load -> run -> finish flow driven by the START / EXECUTE
//            buttons, hands off to the program loader and the core, converts
//            the result register to BCD one bit per cycle and produces the
//            per-digit display codes for the 7-segment driver.
// Options  : `define WATCHDOG_EN adds a cycle-limit watchdog (TIMEOUT state).
//            Without it the run leaves EXEC only when pc passes END_PC and
//            timeout is tied low.
// Ports    : CLK              system clock
//            RESET_N          synchronous, active-low reset
//            START, EXECUTE   raw button levels, active-high
//            program_loaded   loader done (level)
//            pc               core's incremented PC
//            result           value to display
//            start_loading    loader enable (level)
//            program_start    core run enable (level)
//            program_finished run complete (level)
//            timeout          watchdog fired (level)
//            bcd_valid        BCD digits on the display are final
//            cycle_count      cycles spent in EXEC, saturating
//            hex_codes        digit i at [4i+3:4i]; a blank, b P, c L, d E,
//                             e t, f F, 0-9 digits
// Revision : 1.0 - initial release
//==============================================================================
module run_control_seq #(
    parameter int PC_WIDTH     = 32,
    parameter int END_PC       = 172,
    parameter int RESULT_WIDTH = 8,
    parameter int NUM_DIGITS   = 6,
    parameter int CNT_WIDTH    = 24,
    parameter int MAX_CYCLES   = 1000000
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    START,
    input  logic                    EXECUTE,
    input  logic                    program_loaded,
    input  logic [PC_WIDTH-1:0]     pc,
    input  logic [RESULT_WIDTH-1:0] result,
    output logic                    start_loading,
    output logic                    program_start,
    output logic                    program_finished,
    output logic                    timeout,
    output logic                    bcd_valid,
    output logic [CNT_WIDTH-1:0]    cycle_count,
    output logic [NUM_DIGITS*4-1:0] hex_codes
);

    localparam int BCD_DIGITS = (RESULT_WIDTH * 301) / 1000 + 1;
    localparam int c_BCNT_W   = $clog2(RESULT_WIDTH + 1);

    localparam logic [c_BCNT_W-1:0] c_LAST_BIT = c_BCNT_W'(RESULT_WIDTH - 1);
    localparam logic [PC_WIDTH-1:0] c_END_PC   = PC_WIDTH'(END_PC);

    // Display glyph codes
    localparam logic [3:0] c_CODE_BLANK = 4'ha;
    localparam logic [3:0] c_CODE_P     = 4'hb;
    localparam logic [3:0] c_CODE_L     = 4'hc;
    localparam logic [3:0] c_CODE_E     = 4'hd;
    localparam logic [3:0] c_CODE_T     = 4'he;
    localparam logic [3:0] c_CODE_F     = 4'hf;

    // State encoding
    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_LOADING = 3'd1;
    localparam logic [2:0] c_LOADED  = 3'd2;
    localparam logic [2:0] c_EXEC    = 3'd3;
    localparam logic [2:0] c_CONVERT = 3'd4;
    localparam logic [2:0] c_DONE    = 3'd5;
`ifdef WATCHDOG_EN
    localparam logic [2:0]           c_TIMEOUT  = 3'd6;
    localparam logic [CNT_WIDTH-1:0] c_WD_LIMIT = CNT_WIDTH'(MAX_CYCLES - 1);
`endif

    logic [2:0]              r_state;
    logic [2:0]              w_state_next;

    // Button synchronisers: meta -> sync -> previous, edge on sync & ~prev
    logic                    r_start_meta;
    logic                    r_start_sync;
    logic                    r_start_prev;
    logic                    r_exec_meta;
    logic                    r_exec_sync;
    logic                    r_exec_prev;
    logic                    w_start_rise;
    logic                    w_exec_rise;

    logic                    w_pc_done;
    logic                    w_wd_hit;

    logic [CNT_WIDTH-1:0]    r_cycle_count;
    logic [RESULT_WIDTH-1:0] r_shift;
    logic [4*BCD_DIGITS-1:0] r_bcd;
    logic [4*BCD_DIGITS-1:0] w_bcd_next;
    logic [c_BCNT_W-1:0]     r_bit_cnt;
    logic                    w_last_bit;

    logic [3:0]              w_top_code;
    logic [3:0]              w_next_code;

    assign w_start_rise = r_start_sync & ~r_start_prev;
    assign w_exec_rise  = r_exec_sync & ~r_exec_prev;
    assign w_pc_done    = (pc > c_END_PC);
    assign w_last_bit   = (r_bit_cnt == c_LAST_BIT);
    assign cycle_count  = r_cycle_count;

`ifdef WATCHDOG_EN
    assign w_wd_hit = (r_cycle_count == c_WD_LIMIT);
`else
    assign w_wd_hit = 1'b0;
    assign timeout  = 1'b0;
    // The limit has no hardware when the watchdog is compiled out.
    if (MAX_CYCLES > 0) begin : g_no_watchdog
    end
`endif

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state and Moore outputs
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        start_loading    = 1'b0;
        program_start    = 1'b0;
        program_finished = 1'b0;
        bcd_valid        = 1'b0;
        w_top_code       = c_CODE_P;
        w_next_code      = c_CODE_BLANK;
`ifdef WATCHDOG_EN
        timeout          = 1'b0;
`endif
        case (r_state)
            c_IDLE: begin
                w_top_code  = c_CODE_L;
                w_next_code = c_CODE_P;
                if (w_start_rise) begin
                    w_state_next = c_LOADING;
                end
            end
            c_LOADING: begin
                w_top_code    = c_CODE_L;
                w_next_code   = c_CODE_P;
                start_loading = 1'b1;
                if (program_loaded) begin
                    w_state_next = c_LOADED;
                end
            end
            c_LOADED: begin
                w_next_code = c_CODE_L;
                if (w_exec_rise) begin
                    w_state_next = c_EXEC;
                end
            end
            c_EXEC: begin
                w_next_code   = c_CODE_E;
                program_start = 1'b1;
                // Finishing takes priority over the watchdog in the same cycle
                if (w_pc_done) begin
                    w_state_next = c_CONVERT;
                end else if (w_wd_hit) begin
`ifdef WATCHDOG_EN
                    w_state_next = c_TIMEOUT;
`else
                    w_state_next = c_EXEC;
`endif
                end
            end
            c_CONVERT: begin
                w_next_code      = c_CODE_F;
                program_finished = 1'b1;
                if (w_last_bit) begin
                    w_state_next = c_DONE;
                end
            end
            c_DONE: begin
                w_next_code      = c_CODE_F;
                program_finished = 1'b1;
                bcd_valid        = 1'b1;
                if (w_start_rise) begin
                    w_state_next = c_LOADING;
                end
            end
`ifdef WATCHDOG_EN
            c_TIMEOUT: begin
                w_next_code = c_CODE_T;
                timeout     = 1'b1;
                if (w_start_rise) begin
                    w_state_next = c_LOADING;
                end
            end
`endif
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Double-dabble step: each digit >= 5 gets +3, then the whole BCD field
    // shifts left by one, taking the next result bit into the LSB. A digit
    // that was >= 5 always carries a 1 into the digit above, so the carry is
    // just the >= 5 test of the lower digit.
    //--------------------------------------------------------------------------
    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_dabble
        logic [3:0] w_digit;
        logic       w_ge5;
        logic       w_carry_in;

        assign w_digit = r_bcd[4*gi +: 4];
        assign w_ge5   = (w_digit >= 4'd5);

        if (gi == 0) begin : g_lsd
            assign w_carry_in = r_shift[RESULT_WIDTH-1];
        end else begin : g_upper
            assign w_carry_in = (r_bcd[4*(gi-1) +: 4] >= 4'd5);
        end

        assign w_bcd_next[4*gi +: 4] = w_ge5 ? {3'(w_digit + 4'd3), w_carry_in}
                                             : {w_digit[2:0], w_carry_in};
    end

    //--------------------------------------------------------------------------
    // Synchronisers, cycle counter and BCD datapath
    //--------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_start_meta  <= 1'b0;
            r_start_sync  <= 1'b0;
            r_start_prev  <= 1'b0;
            r_exec_meta   <= 1'b0;
            r_exec_sync   <= 1'b0;
            r_exec_prev   <= 1'b0;
            r_cycle_count <= '0;
            r_shift       <= '0;
            r_bcd         <= '0;
            r_bit_cnt     <= '0;
        end else begin
            r_start_meta <= START;
            r_start_sync <= r_start_meta;
            r_start_prev <= r_start_sync;
            r_exec_meta  <= EXECUTE;
            r_exec_sync  <= r_exec_meta;
            r_exec_prev  <= r_exec_sync;

            // Counter is cleared on EXEC entry and otherwise held outside EXEC
            if (r_state == c_LOADED && w_exec_rise) begin
                r_cycle_count <= '0;
            end else if (r_state == c_EXEC && r_cycle_count != '1) begin
                r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
            end

            if (r_state == c_EXEC && w_pc_done) begin
                r_shift   <= result;
                r_bcd     <= '0;
                r_bit_cnt <= '0;
            end else if (r_state == c_CONVERT) begin
                r_bcd     <= w_bcd_next;
                r_shift   <= {r_shift[RESULT_WIDTH-2:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + c_BCNT_W'(1);
            end else if (r_state == c_DONE && w_start_rise) begin
                r_bcd <= '0;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Display codes: two status glyphs on top, BCD digits at the bottom
    // (shown only once final), everything else blank.
    //--------------------------------------------------------------------------
    for (genvar gd = 0; gd < NUM_DIGITS; gd++) begin : g_hex
        if (gd == NUM_DIGITS - 1) begin : g_top
            assign hex_codes[4*gd +: 4] = w_top_code;
        end else if (gd == NUM_DIGITS - 2) begin : g_second
            assign hex_codes[4*gd +: 4] = w_next_code;
        end else if (gd < BCD_DIGITS) begin : g_bcd
            assign hex_codes[4*gd +: 4] = bcd_valid ? r_bcd[4*gd +: 4] : c_CODE_BLANK;
        end else begin : g_blank
            assign hex_codes[4*gd +: 4] = c_CODE_BLANK;
        end
    end

endmodule
`default_nettype wire
